// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: rotating-priority winner selection, grant held until the owner releases.
// Optional grant timeout enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter8 #(
  parameter int N       = 8,
  parameter int IDXW    = 3,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [IDXW-1:0] ptr_reg, ptr_next;
  logic [N-1:0]    gnt_reg, gnt_next;
  logic [IDXW-1:0] idx_reg, idx_next;
  logic            valid_reg, valid_next;

  logic [IDXW-1:0] cand_idx [N];
  logic [N-1:0]    cand_hit;
  logic            win_any;
  logic [IDXW-1:0] win_idx;
  logic            release_now;
  logic            drop_grant;
  logic [IDXW-1:0] ptr_after;

  generate
    if (N < 2 || N > 16 || IDXW != $clog2(N) || TIMEOUT < 2) begin : g_bad_params
      $error("rr_arbiter8: illegal parameter combination");
    end
  endgenerate

  // Candidate gi is the requester at search position gi, counted from ptr with wrap at N.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IDXW:0] sum;
      assign sum          = {1'b0, ptr_reg} + (IDXW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDXW+1)'(N)) ? IDXW'(sum - (IDXW+1)'(N)) : sum[IDXW-1:0];
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    win_any = |req;
    win_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        win_idx = cand_idx[k];
      end
    end
  end

  assign release_now = !en || !req[idx_reg];
  assign ptr_after   = (idx_reg == IDXW'(N - 1)) ? '0 : idx_reg + IDXW'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT);

  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic            timeout_reg, timeout_next;
  logic            expired;

  assign expired = (cnt_reg == CNTW'(TIMEOUT - 1));
`endif

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    drop_grant = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_next     = cnt_reg;
    timeout_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (en && win_any) begin
          state_next = GRANT;
          gnt_next   = {{(N-1){1'b0}}, 1'b1} << win_idx;
          idx_next   = win_idx;
          valid_next = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end
      GRANT: begin
        if (release_now) begin
          drop_grant = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (expired) begin
          // A normal release on the same edge takes the branch above, so no pulse then.
          drop_grant   = 1'b1;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNTW'(1);
`endif
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (drop_grant) begin
      state_next = IDLE;
      ptr_next   = ptr_after;
      gnt_next   = '0;
      idx_next   = '0;
      valid_next = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_next   = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      gnt_reg   <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_reg;
  assign gnt_idx   = idx_reg;
  assign gnt_valid = valid_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: expected outputs are queued as stimulus is driven and
// compared one edge later.
module tb_rr_arbiter8;

  localparam int N       = 8;
  localparam int IDXW    = 3;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;
  logic            timeout;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic         to;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  rr_arbiter8 #(.N(N), .IDXW(IDXW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [IDXW-1:0] idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) begin
      if (g[i]) return IDXW'(i);
    end
    return '0;
  endfunction

  task automatic check_out(input string tag, input logic [N-1:0] eg, input logic et);
    logic [N+IDXW+1:0] obs;
    logic [N+IDXW+1:0] expv;
    obs  = {gnt, gnt_idx, gnt_valid, timeout};
    expv = {eg, idx_of(eg), |eg, et};
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
             tag, gnt, gnt_idx, gnt_valid, timeout, eg, idx_of(eg), |eg, et);
    end
    $display("%s: gnt=%h idx=%0d valid=%b timeout=%b", tag, gnt, gnt_idx, gnt_valid, timeout);
  endtask

  task automatic step(input string tag, input logic e, input logic [N-1:0] r,
                      input logic [N-1:0] eg, input logic et = 1'b0);
    exp_t ex;
    en  = e;
    req = r;
    sb.push_back('{gnt: eg, to: et});
    @(posedge clk);
    #1;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s: scoreboard empty, got size=%0d want nonzero", tag, sb.size());
    end
    if (sb.size() != 0) begin
      ex = sb.pop_front();
      check_out(tag, ex.gnt, ex.to);
    end
  endtask

  // Asynchronous reset pulse inside the current cycle; outputs must clear immediately.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_out(tag, '0, 1'b0);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] oh;
    rst = 1'b1;
    en  = 1'b0;
    req = '0;
    #12 check_out("reset_state", '0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset behaviour
    step("rst_grant3", 1'b1, 8'h08, 8'h08);
    step("rst_rel3",   1'b1, 8'h00, 8'h00);
    step("rst_grant5", 1'b1, 8'h20, 8'h20);
    step("rst_hold5",  1'b1, 8'h20, 8'h20);
    async_reset("rst_async_mid5");
    step("rst_regrant3", 1'b1, 8'h08, 8'h08);
    step("rst_hold3",    1'b1, 8'h08, 8'h08);
    async_reset("rst_async_mid3");

    // Rotation: ptr back at 0 after reset, order 0..7 then 0
    for (int k = 0; k <= N; k++) begin
      oh = '0;
      oh[k % N] = 1'b1;
      step($sformatf("rot_grant%0d", k % N), 1'b1, 8'hFF, oh);
      step($sformatf("rot_hold%0d", k % N),  1'b1, 8'hFF, oh);
      step($sformatf("rot_rel%0d", k % N),   1'b1, 8'hFF & ~oh, 8'h00);
    end

    // Pointer wrap (ptr=1 here)
    step("wrap_grant5", 1'b1, 8'h20, 8'h20);
    step("wrap_rel5",   1'b1, 8'h00, 8'h00);
    step("wrap_grant7", 1'b1, 8'h81, 8'h80);
    step("wrap_rel7",   1'b1, 8'h01, 8'h00);
    step("wrap_grant0", 1'b1, 8'h81, 8'h01);
    step("wrap_rel0",   1'b1, 8'h00, 8'h00);

    // Hold, no preemption (ptr=1)
    step("hold_grant2",  1'b1, 8'h04, 8'h04);
    step("hold_keep2",   1'b1, 8'h04, 8'h04);
    step("hold_preempt", 1'b1, 8'h05, 8'h04);
    step("hold_still2",  1'b1, 8'h05, 8'h04);
    step("hold_rel2",    1'b1, 8'h01, 8'h00);
    step("hold_grant0",  1'b1, 8'h01, 8'h01);
    step("hold_rel0",    1'b1, 8'h00, 8'h00);

    // Enable (ptr=1)
    step("en_off_a",      1'b0, 8'hFF, 8'h00);
    step("en_off_b",      1'b0, 8'hFF, 8'h00);
    step("en_off_c",      1'b0, 8'hFF, 8'h00);
    step("en_on_grant1",  1'b1, 8'hFF, 8'h02);
    step("en_rel1",       1'b1, 8'hFD, 8'h00);
    step("en_grant4",     1'b1, 8'h10, 8'h10);
    step("en_hold4",      1'b1, 8'hFF, 8'h10);
    step("en_drop4",      1'b0, 8'hFF, 8'h00);
    step("en_idle_off",   1'b0, 8'hFF, 8'h00);
    step("en_grant5",     1'b1, 8'hFF, 8'h20);
    step("en_rel5",       1'b1, 8'hDF, 8'h00);

`ifdef ARB_TIMEOUT_EN
    // Forced release after TIMEOUT cycles of continuous ownership
    async_reset("to_reset");
    step("to_grant1", 1'b1, 8'h02, 8'h02);
    for (int c = 1; c < TIMEOUT; c++) begin
      step($sformatf("to_hold%0d", c), 1'b1, 8'h02, 8'h02);
    end
    step("to_forced", 1'b1, 8'hFF, 8'h00, 1'b1);
    step("to_next2",  1'b1, 8'hFF, 8'h04, 1'b0);
    step("to_rel2",   1'b1, 8'hFB, 8'h00, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
